// File: rtl/stream_sink_checker.sv
// Val/rdy test sink: compares an incoming stream against a loadable table of
// expected messages, with LFSR-driven backpressure, error capture and a cycle limit.
module stream_sink_checker #(
  parameter int          p_msg_nbits = 32,
  parameter int          p_depth     = 16,
  parameter int          p_timeout   = 1000000,
  parameter logic [31:0] p_seed      = 32'hdeadbeef
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_en,
  input  logic [$clog2(p_depth)-1:0]   load_addr,
  input  logic [p_msg_nbits-1:0]       load_data,
  input  logic [$clog2(p_depth):0]     num_msgs,
  input  logic [1:0]                   stall_mode,
  input  logic                         start,
  input  logic                         istream_val,
  output logic                         istream_rdy,
  input  logic [p_msg_nbits-1:0]       istream_msg,
  output logic                         done,
  output logic                         timeout,
  output logic                         failed,
  output logic [$clog2(p_depth):0]     err_count,
  output logic [$clog2(p_depth)-1:0]   err_idx,
  output logic [p_msg_nbits-1:0]       err_actual,
  output logic [p_msg_nbits-1:0]       err_expected,
  output logic [31:0]                  cycles
);
  localparam int AW = $clog2(p_depth);
  localparam int CW = AW + 1;
  localparam logic [31:0] TAPS  = 32'h80200003;
  localparam logic [31:0] LIMIT = 32'(p_timeout - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;

  state_t                 state, state_nx;
  logic [p_msg_nbits-1:0] tbl [p_depth];
  logic [31:0]            lfsr;
  logic [AW-1:0]          idx;
  logic [CW-1:0]          cnt;
  logic                   stall, xfer, last, mismatch, launch;

  assign launch   = (state != RUN) && start;
  assign xfer     = istream_val && istream_rdy;
  assign last     = ({1'b0, idx} == cnt - 1'b1);
  assign mismatch = (istream_msg !== tbl[idx]);

  always_comb begin
    stall = 1'b0;
    case (stall_mode)
      2'd1:    stall = (lfsr[1:0] == 2'd0);
      2'd2:    stall = !lfsr[0];
      2'd3:    stall = (lfsr[1:0] != 2'd3);
      default: stall = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a final transfer on the limit cycle resolves to DONE
  always_comb begin
    state_nx = state;
    case (state)
      RUN: begin
        if (cnt == '0)          state_nx = DONE;
        else if (xfer && last)  state_nx = DONE;
        else if (cycles == LIMIT) state_nx = TIMEOUT;
      end
      default: if (start) state_nx = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    istream_rdy = (state == RUN) && (cnt != '0) && !stall;
    done        = (state == DONE);
    timeout     = (state == TIMEOUT);
    failed      = (err_count != '0) || timeout;
  end

  // Expected table: not reset, frozen while a run is in progress
  always_ff @(posedge clk) begin
    if (load_en && state != RUN) tbl[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      lfsr         <= p_seed;
      idx          <= '0;
      cycles       <= '0;
      err_count    <= '0;
      err_idx      <= '0;
      err_actual   <= '0;
      err_expected <= '0;
      if (rst)                          cnt <= '0;
      else if (num_msgs > CW'(p_depth)) cnt <= CW'(p_depth);
      else                              cnt <= num_msgs;
    end else if (state == RUN) begin
      lfsr   <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
      cycles <= cycles + 32'd1;
      if (xfer) begin
        idx <= idx + 1'b1;
        if (mismatch) begin
          err_count <= err_count + 1'b1;
          if (err_count == '0) begin
            err_idx      <= idx;
            err_actual   <= istream_msg;
            err_expected <= tbl[idx];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed bench for stream_sink_checker: a default-limit instance for the
// functional runs and a 20-cycle-limit instance for the timeout boundary.
module tb_stream_sink_checker;
  logic        clk = 1'b0;
  logic        rst, load_en, start, val;
  logic [3:0]  load_addr;
  logic [31:0] load_data, msg;
  logic [4:0]  num_msgs;
  logic [1:0]  stall_mode;

  logic        rdy, done, timeout, failed;
  logic [4:0]  err_count;
  logic [3:0]  err_idx;
  logic [31:0] err_actual, err_expected, cycles;

  logic        t_rdy, t_done, t_timeout, t_failed;
  logic [4:0]  t_err_count;
  logic [3:0]  t_err_idx;
  logic [31:0] t_err_actual, t_err_expected, t_cycles;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_sink_checker dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .num_msgs(num_msgs), .stall_mode(stall_mode), .start(start),
    .istream_val(val), .istream_rdy(rdy), .istream_msg(msg),
    .done(done), .timeout(timeout), .failed(failed), .err_count(err_count),
    .err_idx(err_idx), .err_actual(err_actual), .err_expected(err_expected), .cycles(cycles));

  stream_sink_checker #(.p_timeout(20)) dut_to (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .num_msgs(num_msgs), .stall_mode(stall_mode), .start(start),
    .istream_val(val), .istream_rdy(t_rdy), .istream_msg(msg),
    .done(t_done), .timeout(t_timeout), .failed(t_failed), .err_count(t_err_count),
    .err_idx(t_err_idx), .err_actual(t_err_actual), .err_expected(t_err_expected), .cycles(t_cycles));

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step;
    load_en = 1'b0;
  endtask

  task automatic begin_run(input logic [4:0] n, input logic [1:0] mode);
    num_msgs = n; stall_mode = mode; start = 1'b1;
    step;
    start = 1'b0;
  endtask

  function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic test_reset;
    rst = 1'b1; step; step; rst = 1'b0;
    n_chk++; if (rdy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || failed !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: rdy/done/timeout/failed=%b%b%b%b required 0000", rdy, done, timeout, failed); end
    n_chk++; if (err_count !== 5'd0 || err_idx !== 4'd0 || cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_counts: err_count=%0d err_idx=%0d cycles=%0d required 0", err_count, err_idx, cycles); end
    n_chk++; if (err_actual !== 32'd0 || err_expected !== 32'd0) begin
      n_fail++; $display("FAIL reset_err_vals: actual=%h expected=%h required 0", err_actual, err_expected); end
  endtask

  task automatic test_basic;
    logic [31:0] e [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) load(4'(i), e[i]);
    begin_run(5'd4, 2'd0);
    for (int i = 0; i < 4; i++) begin
      val = 1'b1; msg = e[i];
      n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy[%0d]: got %b required 1", i, rdy); end
      if (i < 3) begin
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done[%0d]: got %b required 0", i, done); end
      end
      step;
    end
    val = 1'b0;
    n_chk++; if (done !== 1'b1 || failed !== 1'b0 || err_count !== 5'd0) begin
      n_fail++; $display("FAIL basic_result: done=%b failed=%b err_count=%0d required 1 0 0", done, failed, err_count); end
    n_chk++; if (cycles !== 32'd4) begin n_fail++; $display("FAIL basic_cycles: got %0d required 4", cycles); end
    step;
    n_chk++; if (rdy !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL basic_hold: rdy=%b done=%b required 0 1", rdy, done); end
  endtask

  task automatic test_mismatch;
    logic [31:0] s [4] = '{32'h11, 32'h99, 32'h33, 32'h55};
    begin_run(5'd4, 2'd0);
    for (int i = 0; i < 4; i++) begin
      val = 1'b1; msg = s[i];
      if (i == 2) begin
        n_chk++; if (err_count !== 5'd1 || err_idx !== 4'd1) begin
          n_fail++; $display("FAIL mm_partial: err_count=%0d err_idx=%0d required 1 1", err_count, err_idx); end
      end
      step;
    end
    val = 1'b0;
    n_chk++; if (err_count !== 5'd2 || failed !== 1'b1 || done !== 1'b1) begin
      n_fail++; $display("FAIL mm_result: err_count=%0d failed=%b done=%b required 2 1 1", err_count, failed, done); end
    n_chk++; if (err_idx !== 4'd1 || err_actual !== 32'h99 || err_expected !== 32'h22) begin
      n_fail++; $display("FAIL mm_capture: idx=%0d actual=%h expected=%h required 1 99 22", err_idx, err_actual, err_expected); end
  endtask

  task automatic test_stall;
    logic [31:0] m;
    int idx, n, stalls;
    logic [255:0] pat [2];
    for (int i = 0; i < 16; i++) load(4'(i), 32'h1000 + 32'(i) * 32'h0101);
    for (int r = 0; r < 2; r++) begin
      begin_run(r == 0 ? 5'd16 : 5'd31, 2'd2);  // second run also exercises saturation
      m = 32'hdeadbeef; idx = 0; n = 0; stalls = 0; pat[r] = '0;
      while (idx < 16 && n < 200) begin
        val = 1'b1; msg = 32'h1000 + 32'(idx) * 32'h0101;
        pat[r][n] = rdy;
        if (rdy !== m[0]) begin n_fail++; $display("FAIL stall_rdy run%0d cyc%0d: got %b required %b", r, n, rdy, m[0]); end
        if (!m[0]) stalls++;
        if (m[0]) idx++;
        m = lfsr_nx(m);
        step; n++;
      end
      val = 1'b0;
      n_chk++;  // aggregate of the per-cycle rdy checks above
      n_chk++; if (stalls == 0) begin n_fail++; $display("FAIL stall_seen run%0d: stalls=0 required >0", r); end
      n_chk++; if (done !== 1'b1 || err_count !== 5'd0 || cycles !== 32'(n)) begin
        n_fail++; $display("FAIL stall_result run%0d: done=%b err=%0d cycles=%0d required 1 0 %0d", r, done, err_count, cycles, n); end
    end
    n_chk++; if (pat[0] !== pat[1]) begin n_fail++; $display("FAIL stall_repeat: pattern %h vs %h", pat[0], pat[1]); end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 3; i++) load(4'(i), 32'h50 + 32'(i));
    begin_run(5'd3, 2'd0);
    for (int c = 0; c < 20; c++) begin
      val = (c < 2); msg = 32'h50 + 32'(c);
      if (c == 19) begin
        n_chk++; if (t_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b required 0", t_timeout); end
      end
      step;
    end
    val = 1'b0;
    n_chk++; if (t_timeout !== 1'b1 || t_failed !== 1'b1 || t_done !== 1'b0) begin
      n_fail++; $display("FAIL to_result: timeout=%b failed=%b done=%b required 1 1 0", t_timeout, t_failed, t_done); end
    n_chk++; if (t_rdy !== 1'b0 || t_cycles !== 32'd20) begin
      n_fail++; $display("FAIL to_after: rdy=%b cycles=%0d required 0 20", t_rdy, t_cycles); end
    // final transfer lands exactly on the limit cycle
    begin_run(5'd3, 2'd0);
    for (int c = 0; c < 20; c++) begin
      val = (c < 2) || (c == 19); msg = 32'h50 + (c == 19 ? 32'd2 : 32'(c));
      step;
    end
    val = 1'b0;
    n_chk++; if (t_done !== 1'b1 || t_timeout !== 1'b0 || t_failed !== 1'b0) begin
      n_fail++; $display("FAIL to_edge: done=%b timeout=%b failed=%b required 1 0 0", t_done, t_timeout, t_failed); end
  endtask

  task automatic test_zero_and_rst;
    begin_run(5'd0, 2'd0);
    val = 1'b1;
    n_chk++; if (rdy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL zero_run: rdy=%b done=%b required 0 0", rdy, done); end
    step; val = 1'b0;
    n_chk++; if (done !== 1'b1 || err_count !== 5'd0) begin n_fail++; $display("FAIL zero_done: done=%b err=%0d required 1 0", done, err_count); end
    // mid-run reset after two transfers, one of them bad
    for (int i = 0; i < 4; i++) load(4'(i), 32'h60 + 32'(i));
    begin_run(5'd4, 2'd0);
    val = 1'b1; msg = 32'h77; step;
    msg = 32'h61; step;
    val = 1'b0;
    n_chk++; if (err_count !== 5'd1 || cycles !== 32'd2) begin
      n_fail++; $display("FAIL rst_pre: err=%0d cycles=%0d required 1 2", err_count, cycles); end
    rst = 1'b1; step; rst = 1'b0;
    n_chk++; if (err_count !== 5'd0 || cycles !== 32'd0 || err_actual !== 32'd0 || err_expected !== 32'd0 || err_idx !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid: err=%0d cycles=%0d act=%h exp=%h idx=%0d required all 0", err_count, cycles, err_actual, err_expected, err_idx); end
    val = 1'b1;
    n_chk++; if (rdy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || failed !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: rdy/done/timeout/failed=%b%b%b%b required 0000", rdy, done, timeout, failed); end
    step; val = 1'b0;
    n_chk++; if (cycles !== 32'd0 || rdy !== 1'b0) begin n_fail++; $display("FAIL rst_stay_idle: cycles=%0d rdy=%b required 0 0", cycles, rdy); end
  endtask

  task automatic test_load_in_run;
    for (int i = 0; i < 3; i++) load(4'(i), 32'hA0 + 32'(i));
    // entry 3 written on the same edge as start
    load_en = 1'b1; load_addr = 4'd3; load_data = 32'h45;
    begin_run(5'd4, 2'd0);
    load_addr = 4'd2; load_data = 32'hEE;  // still asserted: must be ignored in RUN
    for (int i = 0; i < 4; i++) begin
      val = 1'b1; msg = (i == 3) ? 32'h45 : 32'hA0 + 32'(i);
      step;
    end
    load_en = 1'b0; val = 1'b0;
    n_chk++; if (done !== 1'b1 || err_count !== 5'd0 || failed !== 1'b0) begin
      n_fail++; $display("FAIL load_run: done=%b err=%0d failed=%b required 1 0 0", done, err_count, failed); end
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; num_msgs = '0;
    stall_mode = '0; start = 1'b0; val = 1'b0; msg = '0;
    test_reset;
    test_basic;
    test_mismatch;
    test_stall;
    test_timeout;
    test_zero_and_rst;
    test_load_in_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
